// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch types (sequencer state, word size, buffered {pc, instr} entry)
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  localparam int INSTR_BYTES = 4;
  localparam int PC_W = 32;
  localparam int INSTR_W = 32;
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer_2.sv
// fetch_buffer_2: 2-entry FIFO; ports clk/rst_n, flush (wins over push), push/din, pop, count, head (oldest entry)
module fetch_buffer_2 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);
  logic [W-1:0] e0_q, e1_q;
  logic [1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      e0_q <= '0;
      e1_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      if (pop) e0_q <= (push && cnt_q == 2'd1) ? din : e1_q;
      else if (push && cnt_q == 2'd0) e0_q <= din;
      if (push && (pop ? cnt_q == 2'd2 : cnt_q == 2'd1)) e1_q <= din;
    end
  assign count = cnt_q;
  assign head = e0_q;
endmodule

// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: drives a sync ROM (rom_addr/rom_en in, rom_data back next cycle), buffers {pc,instr}, delivers out_* via valid/ready; start, redirect_*, halted, align_err, fetch_count
module instr_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W     = 32,
  parameter int                 DATA_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter logic [DATA_W-1:0]  HALT_INSTR = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic              align_err,
  output logic [31:0]       fetch_count
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, inf_pc_q;
  logic inflight_q, inf_epoch_q, epoch_q, align_err_q;
  logic [31:0] fetch_count_q;
  logic [1:0] count;
  logic run, redir, pop, halt_pop, push, flush, issue;
  assign run = state_q == RUN;
  assign redir = run & redirect_valid;
  assign out_valid = run & ~redirect_valid & (count != 2'd0);
  assign pop = out_valid & out_ready;
  assign halt_pop = pop & (out_instr == HALT_INSTR);
  assign issue = run & ~redirect_valid & (({1'b0, count} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);
  assign push = inflight_q & (inf_epoch_q == epoch_q);
  assign flush = redir | halt_pop;
  fetch_buffer_2 #(.W(ADDR_W + DATA_W)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .push(push),
    .din({inf_pc_q, rom_data}),
    .pop(pop),
    .count(count),
    .head({out_pc, out_instr})
  );
  always_comb state_d = (state_q != RUN) ? (start ? RUN : state_q) : (halt_pop ? HALTED : RUN);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q <= RESET_PC;
      inf_pc_q <= '0;
      inflight_q <= 1'b0;
      inf_epoch_q <= 1'b0;
      epoch_q <= 1'b0;
      align_err_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inf_pc_q <= pc_q;
        inf_epoch_q <= epoch_q;
      end
      if (start && !run) pc_q <= RESET_PC;
      else if (redir) pc_q <= {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (issue) pc_q <= pc_q + ADDR_W'(INSTR_BYTES);
      if (flush) epoch_q <= ~epoch_q;
      if (redir && redirect_pc[1:0] != 2'b00) align_err_q <= 1'b1;
      if (pop && !(&fetch_count_q)) fetch_count_q <= fetch_count_q + 32'd1;
    end
  assign rom_addr = pc_q;
  assign rom_en = issue;
  assign halted = state_q == HALTED;
  assign align_err = align_err_q;
  assign fetch_count = fetch_count_q;
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb_instr_fetch_sequencer: randomized and directed checks of instr_fetch_sequencer against a stream-level model
module tb_instr_fetch_sequencer;
  import fetch_pkg::*;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  logic clk = 1'b0;
  logic rst_n, start, redirect_valid, out_ready, rom_en, out_valid, halted, align_err;
  logic [31:0] rom_addr, rom_data, redirect_pc, out_instr, out_pc, fetch_count, fc_exp;
  logic [31:0] halt_at[$];
  int vectors = 0;
  int errors = 0;
  always #5 clk = ~clk;
  instr_fetch_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .rom_addr(rom_addr),
    .rom_en(rom_en),
    .rom_data(rom_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .halted(halted),
    .align_err(align_err),
    .fetch_count(fetch_count)
  );
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    foreach (halt_at[i]) if (halt_at[i] == a) return HALT;
    return 32'h5A00_0000 ^ {a[31:2], 2'b11};
  endfunction
  function automatic fetch_entry_t ent(input logic [31:0] a);
    return {a, rom_word(a)};
  endfunction
  always @(posedge clk) if (rom_en) rom_data <= rom_word(rom_addr);
  task automatic cyc(input logic st, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    start = st;
    redirect_valid = rv;
    redirect_pc = rpc;
    out_ready = rdy;
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    halt_at.delete();
    fc_exp = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    fc_exp = '0;
    #3;
    vectors++;
    if ({out_valid, rom_en, halted, align_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got v=%b en=%b h=%b ae=%b want all 0", out_valid, rom_en, halted, align_err);
    end
    vectors++;
    if ({fetch_count, out_pc, out_instr} !== 96'b0) begin
      errors++;
      $display("FAIL reset_data got cnt=%h pc=%h instr=%h want 0", fetch_count, out_pc, out_instr);
    end
    vectors++;
    if (rom_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr got %h want 00000000", rom_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if (out_valid !== 1'b0 || rom_en !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet got v=%b en=%b want 0 0", out_valid, rom_en);
      end
    end
  endtask
  task automatic test_linear();
    do_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL linear_latency cycle %0d got v=%b want 0", k + 1, out_valid);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if (out_valid !== 1'b1 || {out_pc, out_instr} !== ent(32'(i * 4))) begin
        errors++;
        $display("FAIL linear_seq got v=%b pc=%h instr=%h want pc=%h", out_valid, out_pc, out_instr, 32'(i * 4));
      end
      fc_exp++;
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (fetch_count !== fc_exp) begin
      errors++;
      $display("FAIL linear_count got %0d want %0d", fetch_count, fc_exp);
    end
  endtask
  task automatic test_backpressure();
    logic [31:0] exp_pc = 32'h10;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || rom_en !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold got v=%b pc=%h en=%b want 1 %h 0", out_valid, out_pc, rom_en, exp_pc);
      end
    end
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if (out_valid !== 1'b1 || {out_pc, out_instr} !== ent(exp_pc)) begin
        errors++;
        $display("FAIL bp_resume got v=%b pc=%h instr=%h want pc=%h", out_valid, out_pc, out_instr, exp_pc);
      end
      exp_pc += 32'd4;
      fc_exp++;
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (fetch_count !== fc_exp) begin
      errors++;
      $display("FAIL bp_count got %0d want %0d", fetch_count, fc_exp);
    end
  endtask
  task automatic test_redirect();
    logic found;
    logic [31:0] tgt[3] = '{32'h40, 32'h44, 32'h40};
    do_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || {out_pc, out_instr} !== ent(32'h0)) begin
      errors++;
      $display("FAIL redir_pre got v=%b pc=%h want 1 00000000", out_valid, out_pc);
    end
    fc_exp++;
    cyc(1'b0, 1'b1, 32'h40, 1'b1);
    vectors++;
    if (out_valid !== 1'b0 || rom_en !== 1'b0) begin
      errors++;
      $display("FAIL redir_cycle got v=%b en=%b want 0 0", out_valid, rom_en);
    end
    for (int t = 0; t < 3; t++) begin
      if (t == 2) begin
        cyc(1'b0, 1'b1, 32'h42, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (align_err !== 1'b1) begin
          errors++;
          $display("FAIL align_set got %b want 1", align_err);
        end
        found = out_valid;
      end else if (t == 0) begin
        found = 1'b0;
      end else begin
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        found = out_valid;
      end
      for (int k = 0; k < 6 && !found; k++) begin
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        found = out_valid;
      end
      vectors++;
      if (!found || {out_pc, out_instr} !== ent(tgt[t])) begin
        errors++;
        $display("FAIL redir_target%0d got v=%b pc=%h instr=%h want pc=%h", t, out_valid, out_pc, out_instr, tgt[t]);
      end
      fc_exp++;
      if (t == 1) begin
        vectors++;
        if (align_err !== 1'b0) begin
          errors++;
          $display("FAIL align_clear got %b want 0", align_err);
        end
      end
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (fetch_count !== fc_exp || align_err !== 1'b1) begin
      errors++;
      $display("FAIL redir_count got cnt=%0d ae=%b want %0d 1", fetch_count, align_err, fc_exp);
    end
  endtask
  task automatic test_halt();
    logic found;
    do_reset();
    halt_at.push_back(32'hC);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      found = 1'b0;
      for (int k = 0; k < 4 && !found; k++) begin
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        found = out_valid;
      end
      vectors++;
      if (!found || {out_pc, out_instr} !== ent(32'(i * 4))) begin
        errors++;
        $display("FAIL halt_seq got v=%b pc=%h instr=%h want pc=%h", out_valid, out_pc, out_instr, 32'(i * 4));
      end
      fc_exp++;
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, k[0], 32'h101, 1'b1);
      vectors++;
      if (halted !== 1'b1 || rom_en !== 1'b0 || out_valid !== 1'b0 || align_err !== 1'b0) begin
        errors++;
        $display("FAIL halt_state got h=%b en=%b v=%b ae=%b want 1 0 0 0", halted, rom_en, out_valid, align_err);
      end
    end
    vectors++;
    if (fetch_count !== fc_exp) begin
      errors++;
      $display("FAIL halt_count got %0d want %0d", fetch_count, fc_exp);
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      found = out_valid;
    end
    vectors++;
    if (!found || halted !== 1'b0 || {out_pc, out_instr} !== ent(32'h0)) begin
      errors++;
      $display("FAIL halt_restart got v=%b h=%b pc=%h want 1 0 00000000", out_valid, halted, out_pc);
    end
  endtask
  task automatic test_wrap();
    logic found = 1'b0;
    do_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    for (int k = 0; k < 6 && !found; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      found = out_valid;
    end
    vectors++;
    if (!found || {out_pc, out_instr} !== ent(32'hFFFF_FFFC)) begin
      errors++;
      $display("FAIL wrap_top got v=%b pc=%h want fffffffc", out_valid, out_pc);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || {out_pc, out_instr} !== ent(32'h0)) begin
      errors++;
      $display("FAIL wrap_zero got v=%b pc=%h want 1 00000000", out_valid, out_pc);
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || rom_en !== 1'b0) begin
      errors++;
      $display("FAIL areset_pre got v=%b en=%b want 1 0", out_valid, rom_en);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, rom_en, halted, align_err, fetch_count, out_pc, out_instr, rom_addr} !== 132'b0) begin
      errors++;
      $display("FAIL areset_now got v=%b en=%b pc=%h instr=%h addr=%h want all 0", out_valid, rom_en, out_pc, out_instr, rom_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if (out_valid !== 1'b0 || rom_en !== 1'b0) begin
        errors++;
        $display("FAIL areset_after got v=%b en=%b want 0 0", out_valid, rom_en);
      end
    end
  endtask
  task automatic test_random();
    logic running = 1'b0;
    logic exp_halt = 1'b0;
    logic exp_align = 1'b0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] rpc;
    logic st, rv, rdy;
    int pops = 0;
    do_reset();
    for (int i = 0; i < 3; i++) halt_at.push_back(32'($urandom_range(4, 255)) << 2);
    for (int n = 0; n < 3000; n++) begin
      st = $urandom_range(0, running ? 29 : 2) == 0;
      rv = $urandom_range(0, 11) == 0;
      rdy = $urandom_range(0, 3) != 0;
      rpc = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF8;
      if ($urandom_range(0, 19) == 0) rpc[1:0] = 2'b10;
      cyc(st, rv, rpc, rdy);
      vectors++;
      if ((!running || rv) && (out_valid !== 1'b0 || rom_en !== 1'b0)) begin
        errors++;
        $display("FAIL rand_quiet n=%0d got v=%b en=%b want 0 0", n, out_valid, rom_en);
      end
      if (running && out_valid === 1'b1 && {out_pc, out_instr} !== ent(exp_pc)) begin
        errors++;
        $display("FAIL rand_stream n=%0d got pc=%h instr=%h want pc=%h instr=%h", n, out_pc, out_instr, exp_pc, rom_word(exp_pc));
      end
      if (halted !== exp_halt || align_err !== exp_align || fetch_count !== fc_exp) begin
        errors++;
        $display("FAIL rand_status n=%0d got h=%b ae=%b cnt=%0d want %b %b %0d", n, halted, align_err, fetch_count, exp_halt, exp_align, fc_exp);
      end
      if (!running) begin
        if (st) begin
          running = 1'b1;
          exp_halt = 1'b0;
          exp_pc = 32'h0;
        end
      end else if (rv) begin
        exp_pc = {rpc[31:2], 2'b00};
        if (rpc[1:0] != 2'b00) exp_align = 1'b1;
      end else if (out_valid === 1'b1 && rdy) begin
        pops++;
        fc_exp++;
        if (rom_word(exp_pc) == HALT) begin
          running = 1'b0;
          exp_halt = 1'b1;
        end
        exp_pc += 32'd4;
      end
    end
    vectors++;
    if (pops < 300) begin
      errors++;
      $display("FAIL rand_liveness got %0d deliveries want at least 300", pops);
    end
  endtask
  initial begin
    test_reset();
    test_linear();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Sequences the synchronous InstructionMemory ROM.
- Owns the PC and issues one word-aligned address per cycle while there is buffer room.
- Captures ROM data, which arrives one cycle after the address, into a 2-entry buffer tagged with its PC.
- Delivers {pc, instr} to decode over a valid/ready handshake; supports branch redirect, halt detection, and a delivered-instruction counter.

Parameters:
- ADDR_W, 32, width of PC / ROM address.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after start.
- HALT_INSTR, 32'hFFFF_FFFF, encoding that halts fetch when delivered.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  pulse: IDLE/HALTED -> RUN, PC <= RESET_PC.
- rom_addr  out  ADDR_W  address to ROM; combinational from pc_q.
- rom_en  out  1  an issue happens this cycle.
- rom_data  in  DATA_W  ROM output, valid the cycle after rom_en.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  ADDR_W  target address.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  decode accepts.
- out_instr  out  DATA_W  head instruction.
- out_pc  out  ADDR_W  head PC.
- halted  out  1  state == HALTED.
- align_err  out  1  sticky: a misaligned redirect_pc was seen.
- fetch_count  out  32  delivered instructions, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc_q=RESET_PC, buffer empty, in-flight cleared, epoch=0.
  - All outputs 0 except rom_addr=RESET_PC.
- States:
  - IDLE: start -> RUN.
  - RUN: HALT_INSTR delivered -> HALTED.
  - HALTED: start -> RUN.
  - start while in RUN is ignored.
- Issue rule:
  - rom_en = RUN & !redirect_valid & (count + inflight - pop) < 2.
  - On issue, pc_q <= pc_q + 4, mod 2^ADDR_W, wrapping FFFF_FFFC -> 0.
  - inflight <= 1 and the issued PC and current epoch are recorded.
- Capture:
  - The cycle after an issue, if the recorded epoch == epoch, {rom_data, pc} is pushed into the buffer.
  - If the epoch does not match, the data is discarded.
  - The buffer never overflows, by the issue rule.
- Throughput and latency:
  - Steady state with out_ready=1 delivers 1 instr/cycle.
  - First out_valid appears 2 cycles after the start edge.
- Delivery:
  - pop = out_valid & out_ready.
  - out_valid = count != 0 & !redirect_valid & state==RUN.
  - Simultaneous push and pop are allowed.
- Redirect (RUN only):
  - Buffer flushed, epoch toggled, pc_q <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - No issue and no pop in that cycle.
  - The first fetch from the target is issued the next cycle.
  - Redirect outranks halt detection and pop.
  - If redirect_pc[1:0] != 0, align_err is set; it clears only on reset.
- Halt:
  - When popped out_instr == HALT_INSTR, the next state is HALTED.
  - The remaining buffer is flushed, epoch toggled, no further issue.
  - The halt instruction itself is counted.
  - redirect_valid is ignored in IDLE/HALTED.
- fetch_count increments on each pop and saturates at FFFF_FFFF. It is not cleared by start.
- Reset mid-operation: everything returns to its reset values immediately; in-flight ROM data is dropped.

Decomposition:
- Package fetch_pkg:
  - state enum {IDLE, RUN, HALTED}.
  - INSTR_BYTES=4.
  - Buffer-entry struct {pc, instr}.
- One sub-module: fetch_buffer_2 (2-entry FIFO with push/pop/flush, count, head outputs).
- Sequencer FSM, PC and epoch logic live in the top.

Test Plan:
- Linear run, ROM[0..3]=A0,A1,A2,A3, out_ready=1, start at t0:
  - out_pc = 0,4,8,12 on consecutive cycles from t0+2.
  - fetch_count=4 after 4 pops.
- Backpressure: out_ready=0 for 5 cycles mid-stream:
  - At most 2 buffered plus none extra issued; rom_en low.
  - No instruction lost or duplicated on resume; order is preserved.
- Redirect with redirect_pc=0x40 while an in-flight fetch of 0x08 is pending:
  - Data for 0x08 is discarded.
  - Next delivered out_pc=0x40, then 0x44.
  - align_err stays 0.
  - A second redirect_pc=0x42 sets align_err=1 and fetches 0x40.
- Halt: ROM[0x0C]=HALT_INSTR:
  - Deliveries at 0,4,8,0x0C, then halted=1 and rom_en=0.
  - No further out_valid.
  - start restarts at RESET_PC.
- Wrap: redirect to 0xFFFF_FFFC:
  - Delivered out_pc = 0xFFFF_FFFC then 0x0000_0000.
- Async reset: drop rst_n mid-cycle during RUN with 2 buffered:
  - All outputs 0 immediately.
  - After release, no out_valid until start.
